// File: rtl/rc522_pkg.sv
// Shared types and register addresses for the RC522 UID reader.
package rc522_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DETECT,
    GAP,
    READ,
    FINISH,
    FAIL
  } state_t;

  // Read-access SPI address bytes (bit 7 set = read).
  localparam logic [7:0] ADDR_STATUS = 8'h88;
  localparam logic [7:0] ADDR_FIFO   = 8'h92;

endpackage

// File: rtl/rc522_spi_xfer.sv
// 16-bit SPI mode-0 transfer: 8 address bits out, then 8 data bits in.
// cs is low for exactly 32 half-periods of CLK_DIV clk cycles each.
module rc522_spi_xfer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic       miso,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx,
  output logic       cs,
  output logic       sck,
  output logic       mosi
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] div;
  logic [4:0]    half;
  logic [7:0]    txsr;

  // Half-period sequencer; mosi moves on falling sck, miso sampled on rising sck.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cs   <= 1'b1;
      sck  <= 1'b0;
      mosi <= 1'b0;
      div  <= '0;
      half <= '0;
      txsr <= '0;
      rx   <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy <= 1'b1;
          cs   <= 1'b0;
          mosi <= addr[7];
          txsr <= {addr[6:0], 1'b0};
          div  <= '0;
          half <= '0;
        end
      end else if (div == DW'(CLK_DIV - 1)) begin
        div  <= '0;
        half <= half + 5'd1;
        if (!sck) begin
          sck <= 1'b1;
          rx  <= {rx[6:0], miso};
        end else begin
          sck <= 1'b0;
          if (half == 5'd31) begin
            busy <= 1'b0;
            done <= 1'b1;
            cs   <= 1'b1;
            mosi <= 1'b0;
          end else begin
            // txsr drains to zeros, so the data phase drives mosi low
            mosi <= txsr[7];
            txsr <= {txsr[6:0], 1'b0};
          end
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rc522_uid_reader.sv
// Polls the RC522 status register for a card, then reads UID_BYTES from the
// FIFO. Every transaction is followed by a GAP so cs stays high GAP_CYC cycles
// between transactions (done cycle + GAP state + launch cycle).
module rc522_uid_reader #(
  parameter int CLK_DIV   = 4,
  parameter int UID_BYTES = 4,
  parameter int MAX_RETRY = 3,
  parameter int GAP_CYC   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [8*UID_BYTES-1:0] uid,
  output logic                   cs,
  output logic                   sck,
  output logic                   mosi,
  input  logic                   miso
);

  import rc522_pkg::*;

  localparam int GL = (GAP_CYC > 2) ? GAP_CYC - 2 : 1;
  localparam int GW = $clog2(GL + 1);
  localparam int BW = $clog2(UID_BYTES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  state_t                 state, nxt;
  logic [GW-1:0]          gcnt;
  logic [BW-1:0]          bcnt;
  logic [RW-1:0]          retry;
  logic                   card;
  logic [8*UID_BYTES-1:0] shreg;
  logic                   x_start, x_busy, x_done;
  logic [7:0]             x_addr, x_rx;

  rc522_spi_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
    .clk  (clk),
    .rst  (rst),
    .start(x_start),
    .addr (x_addr),
    .miso (miso),
    .busy (x_busy),
    .done (x_done),
    .rx   (x_rx),
    .cs   (cs),
    .sck  (sck),
    .mosi (mosi)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    nxt     = state;
    x_start = 1'b0;
    x_addr  = ADDR_STATUS;
    busy    = 1'b1;
    done    = 1'b0;
    error   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) nxt = DETECT;
      end
      DETECT: begin
        x_start = !x_busy && !x_done;
        if (x_done) begin
          if (x_rx[0])                           nxt = GAP;
          else if (retry == RW'(MAX_RETRY - 1))  nxt = FAIL;
          else                                   nxt = GAP;
        end
      end
      GAP: begin
        if (gcnt == GW'(GL - 1)) begin
          if (!card)                           nxt = DETECT;
          else if (bcnt == BW'(UID_BYTES))     nxt = FINISH;
          else                                 nxt = READ;
        end
      end
      READ: begin
        x_addr  = ADDR_FIFO;
        x_start = !x_busy && !x_done;
        if (x_done) nxt = GAP;
      end
      FINISH: begin
        busy = 1'b0;
        done = 1'b1;
        nxt  = IDLE;
      end
      FAIL: begin
        busy  = 1'b0;
        done  = 1'b1;
        error = 1'b1;
        nxt   = IDLE;
      end
      default: begin
        busy = 1'b0;
        nxt  = IDLE;
      end
    endcase
  end

  // Gap timer, retry/byte counters, UID shift register and committed UID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt  <= '0;
      bcnt  <= '0;
      retry <= '0;
      card  <= 1'b0;
      shreg <= '0;
      uid   <= '0;
    end else begin
      gcnt <= (state == GAP) ? gcnt + 1'b1 : '0;
      case (state)
        IDLE: begin
          if (start) begin
            retry <= '0;
            card  <= 1'b0;
            bcnt  <= '0;
          end
        end
        DETECT: begin
          if (x_done) begin
            if (x_rx[0]) card  <= 1'b1;
            else         retry <= retry + 1'b1;
          end
        end
        READ: begin
          if (x_done) begin
            shreg <= {shreg[8*UID_BYTES-9:0], x_rx};
            bcnt  <= bcnt + 1'b1;
          end
        end
        GAP: begin
          // commit in one step as FINISH is entered, so uid is valid with done
          if (nxt == FINISH) uid <= shreg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc522_uid_reader.sv
// Scoreboard bench: two readers (4-byte/CLK_DIV 4 and 7-byte/CLK_DIV 2) share
// clk/rst. Stimulus queues expected SPI addresses and completions; a negedge
// monitor acts as the RC522 (serving miso from a response queue) and checks.
module tb_rc522_uid_reader;

  localparam int MR = 3;
  localparam int GP = 8;
  localparam logic [1:0][7:0] CDV = {8'd2, 8'd4};
  localparam logic [1:0][7:0] UBV = {8'd7, 8'd4};

  typedef struct {
    bit          isdone;
    logic [79:0] val;
    bit          err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  start = '0;
  logic [1:0]  miso = '0;
  logic [1:0]  cs, sck, mosi, busy, done, error;
  logic [79:0] uid_w [2];

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int U = int'(UBV[g]);
    logic [8*U-1:0] u;
    rc522_uid_reader #(
      .CLK_DIV(int'(CDV[g])), .UID_BYTES(U), .MAX_RETRY(MR), .GAP_CYC(GP)
    ) dut (
      .clk(clk), .rst(rst), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .error(error[g]), .uid(u), .cs(cs[g]), .sck(sck[g]), .mosi(mosi[g]),
      .miso(miso[g])
    );
    assign uid_w[g] = 80'(u);
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        exp_q [$];
  logic [7:0]  rsp_q [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          t0 = 0;
  logic [79:0] last_uid [2];
  logic [7:0]  fb [10];
  int          cs_fall [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};

  task automatic chk(input string nm, input bit ok, input logic [79:0] act, input logic [79:0] req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // RC522 model and scoreboard monitor
  int         rises [2] = '{0, 0};
  int         last_rise [2] = '{0, 0};
  logic [7:0] ash [2];
  logic [7:0] dsh [2];
  logic       pcs [2] = '{1'b1, 1'b1};
  logic       psck [2] = '{1'b0, 1'b0};
  logic       pmosi [2] = '{1'b0, 1'b0};
  logic       pdone [2] = '{1'b0, 1'b0};
  exp_t       me;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (cs[g]) begin
        chk("sck_idle_low", sck[g] == 1'b0, 80'(sck[g]), 80'd0);
        rises[g] = 0;
        miso[g]  = 1'b0;
      end else begin
        if (pcs[g]) cs_fall[g]++;
        if (psck[g] && sck[g])
          chk("mosi_stable_sck_high", mosi[g] == pmosi[g], 80'(mosi[g]), 80'(pmosi[g]));
        if (!psck[g] && sck[g]) begin
          rises[g]++;
          if (rises[g] > 1)
            chk("sck_period", cyc - last_rise[g] == 2 * int'(CDV[g]),
                80'(cyc - last_rise[g]), 80'(2 * int'(CDV[g])));
          last_rise[g] = cyc;
          if (rises[g] <= 8) ash[g] = {ash[g][6:0], mosi[g]};
          else chk("mosi_data_phase", mosi[g] == 1'b0, 80'(mosi[g]), 80'd0);
          if (rises[g] == 8) begin
            if (exp_q.size() == 0 || exp_q[0].isdone) begin
              chk("unexpected_xfer", 1'b0, 80'(ash[g]), 80'd0);
            end else begin
              me = exp_q.pop_front();
              chk("spi_addr", ash[g] == me.val[7:0], 80'(ash[g]), me.val);
            end
          end
        end
        if (psck[g] && !sck[g] && rises[g] >= 8 && rises[g] < 16) begin
          if (rises[g] == 8) dsh[g] = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'h00;
          miso[g] = dsh[g][15 - rises[g]];
        end
      end
      if (done[g]) begin
        done_cnt[g]++;
        chk("done_one_cycle", !pdone[g], 80'(pdone[g]), 80'd0);
        if (exp_q.size() == 0 || !exp_q[0].isdone) begin
          chk("unexpected_done", 1'b0, 80'(done[g]), 80'd0);
        end else begin
          me = exp_q.pop_front();
          chk("error_flag", error[g] == me.err, 80'(error[g]), 80'(me.err));
          chk("uid", uid_w[g] == me.val, uid_w[g], me.val);
          if (me.lat >= 0)
            chk("latency", (cyc - t0 - 1 - me.lat) inside {[-2:2]}, 80'(cyc - t0 - 1), 80'(me.lat));
        end
      end
      if (error[g] && !done[g]) chk("error_without_done", 1'b0, 80'd1, 80'd0);
      pcs[g]   = cs[g];
      psck[g]  = sck[g];
      pmosi[g] = mosi[g];
      pdone[g] = done[g];
    end
  end

  task automatic push_addr(input logic [7:0] a);
    exp_t e;
    e.isdone = 1'b0; e.val = 80'(a); e.err = 1'b0; e.lat = -1;
    exp_q.push_back(e);
  endtask

  // One operation: nfail absent-card polls (>= MR means failure), then UID read.
  task automatic run_op(input int g, input int nfail, input bit fixed, input bit repulse, input bit wait_end);
    exp_t        e;
    logic [79:0] u = '0;
    logic [7:0]  b;
    int ub   = int'(UBV[g]);
    int unit = 32 * int'(CDV[g]) + GP;
    int ntr, base, budget;
    bit seen = 1'b0;
    for (int i = 0; i < nfail && i < MR; i++) begin
      push_addr(8'h88);
      b = fixed ? 8'h00 : (8'($urandom) & 8'hFE);
      rsp_q.push_back(b);
    end
    e.isdone = 1'b1;
    if (nfail >= MR) begin
      ntr = MR;
      e.val = last_uid[g]; e.err = 1'b1; e.lat = -1;
    end else begin
      ntr = nfail + 1 + ub;
      push_addr(8'h88);
      b = fixed ? 8'h01 : (8'($urandom) | 8'h01);
      rsp_q.push_back(b);
      for (int k = 0; k < ub; k++) begin
        push_addr(8'h92);
        b = fixed ? fb[k] : 8'($urandom);
        rsp_q.push_back(b);
        u = (u << 8) | 80'(b);
      end
      e.val = u; e.err = 1'b0; e.lat = (nfail + 1 + ub) * unit;
      last_uid[g] = u;
    end
    exp_q.push_back(e);
    base = cs_fall[g];
    @(posedge clk); #1 start[g] = 1'b1; t0 = cyc;
    @(posedge clk); #1 start[g] = 1'b0;
    chk("busy_after_start", busy[g] == 1'b1, 80'(busy[g]), 80'd1);
    if (repulse) begin
      repeat (3) begin
        repeat (40) @(posedge clk);
        #1 start[g] = 1'b1;
        @(posedge clk); #1 start[g] = 1'b0;
      end
    end
    if (!wait_end) return;
    budget = (ntr + 2) * unit + 200;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done[g]) begin
        seen = 1'b1;
        if (repulse) begin
          start[g] = 1'b1;
          @(posedge clk); #1 start[g] = 1'b0;
        end
      end
    end
    chk("done_timeout", seen, 80'(seen), 80'd1);
    repeat (GP + 10) @(negedge clk);
    chk("idle_busy", busy[g] == 1'b0, 80'(busy[g]), 80'd0);
    chk("xfer_count", cs_fall[g] - base == ntr, 80'(cs_fall[g] - base), 80'(ntr));
    chk("queue_drained", exp_q.size() == 0, 80'(exp_q.size()), 80'd0);
    exp_q.delete();
    rsp_q.delete();
  endtask

  int base0, dcnt;

  initial begin
    last_uid[0] = '0;
    last_uid[1] = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_cs",    cs[g] == 1'b1,    80'(cs[g]),    80'd1);
      chk("rst_sck",   sck[g] == 1'b0,   80'(sck[g]),   80'd0);
      chk("rst_mosi",  mosi[g] == 1'b0,  80'(mosi[g]),  80'd0);
      chk("rst_busy",  busy[g] == 1'b0,  80'(busy[g]),  80'd0);
      chk("rst_done",  done[g] == 1'b0,  80'(done[g]),  80'd0);
      chk("rst_error", error[g] == 1'b0, 80'(error[g]), 80'd0);
      chk("rst_uid",   uid_w[g] == '0,   uid_w[g],      80'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    fb[0] = 8'hAB; fb[1] = 8'hCD; fb[2] = 8'hEF; fb[3] = 8'h12;
    run_op(0, 0, 1'b1, 1'b0, 1'b1);            // card present first poll
    run_op(0, 3, 1'b1, 1'b0, 1'b1);            // no card: error, uid kept
    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;
    run_op(0, 1, 1'b1, 1'b0, 1'b1);            // one miss then card
    run_op(0, 0, 1'b0, 1'b1, 1'b1);            // start re-pulsed while busy
    repeat (4) run_op(0, int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b1);

    repeat (3) run_op(1, int'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b1);
    run_op(1, 3, 1'b0, 1'b0, 1'b1);

    // reset during the third FIFO read
    base0 = cs_fall[0];
    run_op(0, 0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3000 && cs_fall[0] < base0 + 4; c++) @(posedge clk);
    chk("reach_third_read", cs_fall[0] >= base0 + 4, 80'(cs_fall[0] - base0), 80'd4);
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_cs",   cs[0] == 1'b1,   80'(cs[0]),   80'd1);
    chk("async_rst_sck",  sck[0] == 1'b0,  80'(sck[0]),  80'd0);
    chk("async_rst_busy", busy[0] == 1'b0, 80'(busy[0]), 80'd0);
    chk("async_rst_uid",  uid_w[0] == '0,  uid_w[0],     80'd0);
    exp_q.delete();
    rsp_q.delete();
    last_uid[0] = '0;
    last_uid[1] = '0;
    dcnt = done_cnt[0];
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (600) @(negedge clk);
    chk("no_done_after_abort", done_cnt[0] == dcnt, 80'(done_cnt[0]), 80'(dcnt));
    chk("idle_cs_after_abort", cs[0] == 1'b1, 80'(cs[0]), 80'd1);

    run_op(0, 0, 1'b0, 1'b0, 1'b1);            // clean operation after abort

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
